rf_write_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order pipeline

---
 rtl/rf_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB and a
// long-latency unit, queueing LU results and draining them in idle slots.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wb_we/wb_addr/wb_data       pipeline write-back request
//   lu_valid/lu_ready           LU result handshake (ready = !full)
//   lu_addr/lu_data             LU result payload
//   rf_we/rf_waddr/rf_wdata     register-file write port (combinational)
//   pipe_stall                  WB held for a forced drain
//   busy_mask                   registers targeted by live queued writes
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [AW-1:0]    lu_addr,
  input  logic [DW-1:0]    lu_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic             pipe_stall,
  output logic [2**AW-1:0] busy_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;

  ent_t head;
  logic empty, full;
  logic wb_req, lu_req, accept;
  logic sel_frc, sel_wb, sel_drn, sel_byp;
  logic push, pop;

  assign head   = fifo_q[rd_q];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign wb_req = wb_we && (wb_addr != '0);
  assign lu_req = lu_valid && (lu_addr != '0);

  assign lu_ready = rst_n && !full;
  assign accept   = lu_valid && lu_ready;

  // Mutually exclusive grant selects, priority FORCE > WB > DRAIN > BYPASS.
  assign sel_frc = rst_n && !empty
                   && (wait_q == WW'(MAX_WAIT));
  assign sel_wb  = rst_n && !sel_frc && wb_req;
  assign sel_drn = rst_n && !sel_frc && !wb_req
                   && !empty;
  assign sel_byp = rst_n && empty && !wb_req
                   && lu_req;

  assign pop  = sel_frc || sel_drn;
  // Address-0 results are accepted but never stored.
  assign push = accept && !sel_byp
                && (lu_addr != '0);

  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pipe_stall = 1'b0;
    unique case (1'b1)
      sel_frc: begin
        pipe_stall = 1'b1;
        rf_we      = head.v;
        rf_waddr   = head.a;
        rf_wdata   = head.d;
      end
      sel_wb: begin
        rf_we    = 1'b1;
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
      end
      sel_drn: begin
        rf_we    = head.v;
        rf_waddr = head.a;
        rf_wdata = head.d;
      end
      sel_byp: begin
        rf_we    = 1'b1;
        rf_waddr = lu_addr;
        rf_wdata = lu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    // WB is younger: queued writes to the same register are dead.
    if (sel_wb) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_q[i].a == wb_addr)
          fifo_d[i].v = 1'b0;
      end
    end
    if (pop) begin
      fifo_d[rd_q].v = 1'b0;
      rd_d = rd_q + PW'(1);
    end
    if (push) begin
      fifo_d[wr_q].v = !(sel_wb
                         && (wb_addr == lu_addr));
      fifo_d[wr_q].a = lu_addr;
      fifo_d[wr_q].d = lu_data;
      wr_d = wr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    wait_d = wait_q;
    if (empty || pop)
      wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT))
      wait_d = wait_q + WW'(1);
  end

  // Valid bits are cleared on pop, so only live entries can be set.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_q[i].v)
        busy_mask[fifo_q[i].a] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenario tasks for rf_write_arbiter
// with hand-computed expectations and a shadow register file.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [31:0] busy_mask;

  int checks;
  int errors;

  logic [31:0] rf_m [32];

  rf_write_arbiter #(
    .DEPTH(2), .MAX_WAIT(4), .AW(5), .DW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_addr(lu_addr), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall),
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_we) rf_m[rf_waddr] <= rf_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h55;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL reset_we: got %0h exp 0", rf_we);
    end
    checks++;
    if (lu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0h exp 0", lu_ready);
    end
    checks++;
    if (busy_mask !== 32'h0) begin
      errors++; $display("FAIL reset_busy: got %0h exp 0", busy_mask);
    end
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %0h exp 0", pipe_stall);
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_bypass();
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hAAAA;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hAAAA}) begin
      errors++;
      $display("FAIL bypass_write: got %0h/%0d/%0h exp 1/5/aaaa",
               rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_ready: got %0h exp 1", lu_ready);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL bypass_empty_we: got %0h exp 0", rf_we);
    end
    checks++;
    if (busy_mask !== 32'h0) begin
      errors++; $display("FAIL bypass_busy: got %0h exp 0", busy_mask);
    end
    tick();
  endtask

  task automatic test_drain();
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h101;
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h101}) begin
      errors++;
      $display("FAIL drain_c0: got %0h/%0d/%0h exp 1/1/101",
               rf_we, rf_waddr, rf_wdata);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      lu_valid = 1'b0;
      wb_we = (c < 3);
      wb_addr = 5'(c + 1);
      wb_data = 32'h100 + c + 1;
      @(negedge clk);
      checks++;
      if (busy_mask[7] !== 1'b1) begin
        errors++;
        $display("FAIL drain_busy7 c%0d: got %0h exp 1", c, busy_mask[7]);
      end
      checks++;
      if (c < 3 && rf_waddr !== 5'(c + 1)) begin
        errors++;
        $display("FAIL drain_wb c%0d: got %0d exp %0d", c, rf_waddr, c + 1);
      end else if (c == 3 && {rf_we, rf_waddr, rf_wdata, pipe_stall}
                   !== {1'b1, 5'd7, 32'h77, 1'b0}) begin
        errors++;
        $display("FAIL drain_pop: got %0h/%0d/%0h/%0h exp 1/7/77/0",
                 rf_we, rf_waddr, rf_wdata, pipe_stall);
      end
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({rf_we, busy_mask} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL drain_after: got %0h/%0h exp 0/0", rf_we, busy_mask);
    end
    tick();
  endtask

  task automatic test_starvation();
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'hA0;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      wb_data = 32'hA0 + c;
      @(negedge clk);
      checks++;
      if ({pipe_stall, rf_waddr, rf_wdata}
          !== {1'b0, 5'd10, 32'hA0 + c}) begin
        errors++;
        $display("FAIL starve_wait c%0d: got %0h/%0d/%0h exp 0/10/%0h",
                 c, pipe_stall, rf_waddr, rf_wdata, 32'hA0 + c);
      end
      tick();
    end
    wb_data = 32'hA5;
    @(negedge clk);
    checks++;
    if ({pipe_stall, rf_we, rf_waddr, rf_wdata}
        !== {1'b1, 1'b1, 5'd9, 32'h99}) begin
      errors++;
      $display("FAIL starve_force: got %0h/%0h/%0d/%0h exp 1/1/9/99",
               pipe_stall, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({pipe_stall, rf_we, rf_waddr, rf_wdata, busy_mask}
        !== {1'b0, 1'b1, 5'd10, 32'hA5, 32'h0}) begin
      errors++;
      $display("FAIL starve_resume: got %0h/%0h/%0d/%0h/%0h exp 0/1/10/a5/0",
               pipe_stall, rf_we, rf_waddr, rf_wdata, busy_mask);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_stale_kill();
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    lu_valid = 1'b1; lu_addr = 5'd4; lu_data = 32'h11;
    tick();
    lu_valid = 1'b0;
    wb_addr = 5'd4; wb_data = 32'h22;
    @(negedge clk);
    checks++;
    if ({busy_mask[4], rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22}) begin
      errors++;
      $display("FAIL stale_wb: got %0h/%0d/%0h exp 1/4/22",
               busy_mask[4], rf_waddr, rf_wdata);
    end
    tick();
    wb_we = 1'b0;
    lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'h88;
    @(negedge clk);
    checks++;
    if ({busy_mask[4], rf_we} !== 2'b00) begin
      errors++;
      $display("FAIL stale_pop: got busy4=%0h we=%0h exp 0/0",
               busy_mask[4], rf_we);
    end
    tick();
    lu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88}) begin
      errors++;
      $display("FAIL stale_nobypass: got %0h/%0d/%0h exp 1/8/88",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_m[4] !== 32'h22) begin
      errors++; $display("FAIL stale_r4: got %0h exp 22", rf_m[4]);
    end
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'hC2;
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC1;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({busy_mask[12], rf_we} !== 2'b00) begin
      errors++;
      $display("FAIL same_cycle_kill: got busy12=%0h we=%0h exp 0/0",
               busy_mask[12], rf_we);
    end
    tick();
    checks++;
    if (rf_m[12] !== 32'hC2) begin
      errors++; $display("FAIL same_cycle_r12: got %0h exp c2", rf_m[12]);
    end
  endtask

  task automatic test_full_x0();
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    lu_valid = 1'b1; lu_addr = 5'd20; lu_data = 32'hA0;
    tick();
    wb_addr = 5'd2; wb_data = 32'h2;
    lu_addr = 5'd21; lu_data = 32'hA1;
    tick();
    wb_addr = 5'd3; wb_data = 32'h3;
    lu_addr = 5'd0; lu_data = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %0h exp 0", lu_ready);
    end
    checks++;
    if (busy_mask !== 32'h0030_0000) begin
      errors++; $display("FAIL full_busy: got %0h exp 300000", busy_mask);
    end
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({lu_ready, rf_we, rf_waddr, rf_wdata}
        !== {1'b0, 1'b1, 5'd20, 32'hA0}) begin
      errors++;
      $display("FAIL full_pop0: got %0h/%0h/%0d/%0h exp 0/1/20/a0",
               lu_ready, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({lu_ready, rf_we, rf_waddr, rf_wdata}
        !== {1'b1, 1'b1, 5'd21, 32'hA1}) begin
      errors++;
      $display("FAIL full_pop1: got %0h/%0h/%0d/%0h exp 1/1/21/a1",
               lu_ready, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({rf_we, busy_mask} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL x0_discard: got %0h/%0h exp 0/0", rf_we, busy_mask);
    end
    tick();
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    lu_valid = 1'b1; lu_addr = 5'd16; lu_data = 32'h100;
    tick();
    wb_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      lu_addr = 5'(16 + k);
      lu_data = 32'h100 + k;
      @(negedge clk);
      checks++;
      if ({rf_we, rf_waddr, rf_wdata}
          !== {1'b1, 5'(15 + k), 32'h100 + k - 1}) begin
        errors++;
        $display("FAIL wrap k%0d: got %0h/%0d/%0h exp 1/%0d/%0h",
                 k, rf_we, rf_waddr, rf_wdata, 15 + k, 32'h100 + k - 1);
      end
      tick();
    end
    lu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd21, 32'h105}) begin
      errors++;
      $display("FAIL wrap_last: got %0h/%0d/%0h exp 1/21/105",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    idle();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    test_reset();
    test_bypass();
    test_drain();
    test_starvation();
    test_stale_kill();
    test_full_x0();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
